// File: rtl/cmd_sequencer_if.sv
// Byte-stream handshake bundle between the host UART and the command sequencer.
// Latency: none, wires only.
// Backpressure: rx_ready throttles the host side, tx_ready throttles the sequencer side.
interface cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/cmd_sequencer.sv
// Host command sequencer: parses UART command bytes, drives CPU control word, bus forces, clock pulses.
// Latency: command accept -> cpu_clk/tx_valid next cycle; register commands land one cycle after the last arg.
// Backpressure: rx_ready only in IDLE/ARG; tx_ready low stalls a reply indefinitely with tx_data held.
// Option: CMDSEQ_ERR_REPLY_EN makes unknown commands also reply 8'h3F.
module cmd_sequencer #(
  parameter int                  CW_WIDTH     = 32,
  parameter logic [CW_WIDTH-1:0] DEFAULT_CW   = '0,
  parameter int                  PULSE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  cmd_sequencer_if.slave      uart,
  input  logic [7:0]          main_bus_in,
  input  logic [15:0]         addr_bus_in,
  input  logic [3:0]          fout,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic [15:0]         addr_out,
  output logic                addr_oe,
  output logic [CW_WIDTH-1:0] control_word,
  output logic                cpu_clk,
  output logic                cpu_iclk,
  output logic                err
);
  localparam int CW_BYTES  = (CW_WIDTH + 7) / 8;
  localparam int ARG_BYTES = (CW_BYTES > 2) ? CW_BYTES : 2;
  localparam int PCNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam int TX_W      = 72;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_EXEC, S_CLK_HI, S_GAP, S_ICLK_HI, S_TX, S_HALT
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cmd;
  logic [ARG_BYTES*8-1:0] arg;
  logic [7:0]             arg_idx, arg_need, rx_need;
  logic [PCNT_W-1:0]      pcnt;
  logic [TX_W-1:0]        tx_sh, tx_load_dat;
  logic [3:0]             tx_left, tx_load_len;
  logic                   tx_vld, rx_rdy, rx_take, tx_take, pulse_done, cmd_known, pulse_state;

  assign rx_rdy        = !rst && (state == S_IDLE || state == S_ARG);
  assign uart.rx_ready = rx_rdy;
  assign uart.tx_valid = tx_vld;
  assign uart.tx_data  = tx_sh[7:0];
  assign rx_take       = uart.rx_valid && rx_rdy;
  assign tx_take       = tx_vld && uart.tx_ready;
  assign pulse_done    = (pcnt == PCNT_W'(PULSE_CYCLES - 1));
  assign pulse_state   = (state == S_CLK_HI || state == S_GAP || state == S_ICLK_HI);

  // Decode of the byte on the rx bus: argument count and reply image (first byte in the low lane).
  always_comb begin
    rx_need     = 8'd0;
    tx_load_dat = '0;
    tx_load_len = 4'd0;
    cmd_known   = 1'b1;
    case (uart.rx_data)
      "A":      rx_need = 8'd2;
      "B":      rx_need = 8'd1;
      "M", "O": rx_need = 8'(CW_BYTES);
      "a":      begin tx_load_dat[15:0] = addr_bus_in;         tx_load_len = 4'd2; end
      "b":      begin tx_load_dat[7:0]  = main_bus_in;         tx_load_len = 4'd1; end
      "s":      begin tx_load_dat[7:0]  = {4'b0000, fout};     tx_load_len = 4'd1; end
      "r":      tx_load_len = 4'd1;
      "I":      begin tx_load_dat = {"M", "V", "g", "o", "l", "i", "r", "e", "V"}; tx_load_len = 4'd9; end
      "R":      begin tx_load_dat[31:0] = {"K", "R", "B", "#"}; tx_load_len = 4'd4; end
      "f", "N", 8'hFF, "c", "C", "T", "Q": ;
      default: begin
        cmd_known = 1'b0;
`ifdef CMDSEQ_ERR_REPLY_EN
        tx_load_dat[7:0] = 8'h3F;
        tx_load_len      = 4'd1;
`endif
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_take) begin
          if (rx_need != 8'd0)          state_nxt = S_ARG;
          else if (tx_load_len != 4'd0) state_nxt = S_TX;
          else begin
            case (uart.rx_data)
              "c", "T": state_nxt = S_CLK_HI;
              "C":      state_nxt = S_ICLK_HI;
              "Q":      state_nxt = S_HALT;
              default:  state_nxt = S_EXEC;
            endcase
          end
        end
      end
      S_ARG:     if (rx_take && arg_idx == arg_need - 8'd1) state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_IDLE;
      S_CLK_HI:  if (pulse_done) state_nxt = (cmd == "T") ? S_GAP : S_IDLE;
      S_GAP:     if (pulse_done) state_nxt = S_ICLK_HI;
      S_ICLK_HI: if (pulse_done) state_nxt = S_IDLE;
      S_TX:      if (tx_take && tx_left == 4'd1) state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd          <= 8'd0;
      arg          <= '0;
      arg_idx      <= 8'd0;
      arg_need     <= 8'd0;
      pcnt         <= '0;
      tx_sh        <= '0;
      tx_left      <= 4'd0;
      tx_vld       <= 1'b0;
      data_out     <= 8'd0;
      data_oe      <= 1'b0;
      addr_out     <= 16'd0;
      addr_oe      <= 1'b0;
      control_word <= DEFAULT_CW;
      cpu_clk      <= 1'b0;
      cpu_iclk     <= 1'b0;
      err          <= 1'b0;
    end else begin
      err      <= 1'b0;
      tx_vld   <= (state_nxt == S_TX);
      cpu_clk  <= (state_nxt == S_CLK_HI);
      cpu_iclk <= (state_nxt == S_ICLK_HI);
      if (state_nxt != state)  pcnt <= '0;
      else if (pulse_state)    pcnt <= pcnt + PCNT_W'(1);
      case (state)
        S_IDLE: begin
          if (rx_take) begin
            cmd      <= uart.rx_data;
            arg      <= '0;
            arg_idx  <= 8'd0;
            arg_need <= rx_need;
            err      <= !cmd_known;
            if (tx_load_len != 4'd0) begin
              tx_sh   <= tx_load_dat;
              tx_left <= tx_load_len;
            end
          end
        end
        S_ARG: begin
          if (rx_take) begin
            for (int i = 0; i < ARG_BYTES; i++)
              if (arg_idx == 8'(i)) arg[i*8 +: 8] <= uart.rx_data;
            arg_idx <= arg_idx + 8'd1;
          end
        end
        S_EXEC: begin
          case (cmd)
            "A": begin addr_out <= arg[15:0]; addr_oe <= 1'b1; end
            "B": begin data_out <= arg[7:0];  data_oe <= 1'b1; end
            "f": begin data_oe <= 1'b0; addr_oe <= 1'b0; end
            "O": begin data_oe <= 1'b0; addr_oe <= 1'b0; control_word <= arg[CW_WIDTH-1:0]; end
            "M": control_word <= arg[CW_WIDTH-1:0];
            default: ;
          endcase
        end
        S_TX: begin
          if (tx_take) begin
            tx_sh   <= {8'h00, tx_sh[TX_W-1:8]};
            tx_left <= tx_left - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
